// File: rtl/ex_mem_flag_pipe.sv
// EX->MEM pipeline register plus the architectural Z/V/N flag register, with stall/flush handling.
// Optional build macro FLAG_BYPASS_EN: flag outputs show next-state flags combinationally.
module ex_mem_flag_pipe #(
   parameter int WIDTH    = 16,
   parameter int REG_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                ex_valid,
   input  logic [3:0]          ex_op,
   input  logic [WIDTH-1:0]    ex_alu_out,
   input  logic                ex_ovfl,
   input  logic [REG_BITS-1:0] ex_rd,
   input  logic                ex_wr_en,
   input  logic                ex_mem_rd,
   input  logic                ex_mem_wr,
   input  logic [WIDTH-1:0]    ex_st_data,
   output logic                mem_valid,
   output logic [WIDTH-1:0]    mem_alu_out,
   output logic [REG_BITS-1:0] mem_rd,
   output logic                mem_wr_en,
   output logic                mem_mem_rd,
   output logic                mem_mem_wr,
   output logic [WIDTH-1:0]    mem_st_data,
   output logic                flag_z,
   output logic                flag_v,
   output logic                flag_n
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SLL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_ROR = 4'b0110;

   logic flush_pend;
   logic fire;
   logic upd_z, upd_n, upd_v;
   logic z_q, v_q, n_q;
   logic z_nxt, v_nxt, n_nxt;

   // A flush seen while stalled is remembered and kills EX at the first unstalled edge.
   assign fire = ~stall & ex_valid & ~flush & ~flush_pend;

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      upd_z = 1'b0;
      upd_n = 1'b0;
      upd_v = 1'b0;
      case (ex_op)
         OP_ADD, OP_SUB: begin
            upd_z = 1'b1;
            upd_n = 1'b1;
            upd_v = 1'b1;
         end
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd_z = 1'b1;
         default: ;
      endcase
   end

   assign z_nxt = (fire & upd_z) ? (ex_alu_out == '0)      : z_q;
   assign n_nxt = (fire & upd_n) ? ex_alu_out[WIDTH-1]     : n_q;
   assign v_nxt = (fire & upd_v) ? ex_ovfl                 : v_q;

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         z_q <= 1'b0;
         v_q <= 1'b0;
         n_q <= 1'b0;
      end else begin
         z_q <= z_nxt;
         v_q <= v_nxt;
         n_q <= n_nxt;
      end
   end

   // NOTE: the whole pipeline register is reset, datapath included, so outputs read 0 after rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid   <= 1'b0;
         mem_alu_out <= '0;
         mem_rd      <= '0;
         mem_wr_en   <= 1'b0;
         mem_mem_rd  <= 1'b0;
         mem_mem_wr  <= 1'b0;
         mem_st_data <= '0;
         flush_pend  <= 1'b0;
      end else if (!stall) begin
         mem_valid   <= fire;
         mem_wr_en   <= fire & ex_wr_en;
         mem_mem_rd  <= fire & ex_mem_rd;
         mem_mem_wr  <= fire & ex_mem_wr;
         mem_alu_out <= ex_alu_out;
         mem_rd      <= ex_rd;
         mem_st_data <= ex_st_data;
         flush_pend  <= 1'b0;
      end else begin
         flush_pend  <= flush_pend | flush;
      end
   end

`ifdef FLAG_BYPASS_EN
   // Same-cycle branches see the flags the current fire will write.
   assign flag_z = z_nxt;
   assign flag_v = v_nxt;
   assign flag_n = n_nxt;
`else
   assign flag_z = z_q;
   assign flag_v = v_q;
   assign flag_n = n_q;
`endif

endmodule
